ssd_scan_driver: RTL and testbench
==================================

Name: ssd_scan_driver

Overview:
- Time-multiplexed driver for a DIGITS-digit common-anode/cathode seven-segment display.
- Scans one digit per refresh tick and decodes each 4-bit hex nibble to segments.
- Double-buffers the displayed value so a frame never shows a half-updated number.
- Sits between the CPU debug/status path (PC, register, ALU result) and the board display pins.

Parameters:
- DIGITS, 4, number of digits/nibbles scanned; legal 1..8.
- CLK_DIV, 50000, clk cycles per digit slot; legal >= 1.
- SEG_ACTIVE_LOW, 1, 1 means segment lit = 0; 0 inverts seg_o.
- AN_ACTIVE_LOW, 1, 1 means selected anode = 0; 0 inverts an_o.

Ports:
- clk, input, 1, system clock; all state on rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- value_i, input, 4*DIGITS, hex value; nibble k shown on digit k, where digit 0 is the rightmost digit.
- load_i, input, 1, single-cycle strobe that captures value_i and blank_i into the shadow register.
- blank_i, input, DIGITS, per-digit force-blank mask, captured with load_i.
- seg_o, output, 7, segments {a,b,c,d,e,f,g}, where seg_o[6]=a and seg_o[0]=g.
- an_o, output, DIGITS, one-hot digit enable.
- frame_o, output, 1, one-cycle pulse when the scan wraps from digit DIGITS-1 to digit 0.

Behaviour:
- Hex table, active-low form {a..g}:
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110
  - 4=1001100, 5=0100100, 6=0100000, 7=0001111
  - 8=0000000, 9=0000100, A=0001000, b=1100000
  - C=0110001, d=1000010, E=0110000, F=0111000
  - When SEG_ACTIVE_LOW=0, every code is bitwise inverted.
- Prescaler:
  - Counts 0..CLK_DIV-1 and wraps to 0.
  - tick is asserted in the cycle when the count equals CLK_DIV-1.
  - With CLK_DIV=1, tick is asserted every cycle.
- Digit index idx:
  - Advances on tick; wraps from DIGITS-1 to 0.
  - With DIGITS=1, idx stays 0 and every tick is a wrap.
- Shadow/active buffering:
  - On load_i, shadow <= {value_i, blank_i} and pending <= 1.
  - On a wrap tick with pending=1, active <= shadow and pending <= 0.
  - If load_i coincides with a wrap tick, the newly captured value goes straight to active and pending ends at 0.
  - A load while pending=1 overwrites the shadow; last write wins.
- Outputs (all registered):
  - seg_o and an_o reflect idx and active one cycle after idx changes.
  - an_o has exactly one active bit, at position idx.
  - A blanked digit drives seg_o to all-off and keeps its anode active.
- frame_o is registered and asserts in the cycle after the wrap tick.
- Reset values:
  - Prescaler=0, idx=0, shadow=0, active=0, pending=0.
  - seg_o=all-off, an_o=all-inactive, frame_o=0.
  - The first clock after rst_n deasserts drives digit 0 showing "0".
- Reset mid-scan: immediate and asynchronous; all state returns to the reset values above and any pending load is discarded.
- load_i held high for several cycles: each cycle is treated as a new load.

Optional Feature:
- Macro: SSD_LZB_EN (leading-zero blanking).
- With the macro defined:
  - Any digit k>0 is blanked if all active nibbles at positions >= k are zero.
  - Digit 0 is never blanked by this rule, so 0x0000 shows "0".
  - This blanking is ORed with blank_i.
- Without the macro: only blank_i blanks digits.

Decomposition:
- Package ssd_pkg contains:
  - The 16-entry SEG_TABLE constant (active-low).
  - The SEG_OFF constant.
  - A clog2-based idx width function.
- One natural sub-module: ssd_hex_decode, a combinational nibble-to-segment decoder parameterised by SEG_ACTIVE_LOW.
- The scan, prescaler and buffering logic stay in the top module.

Test Plan (DIGITS=4, CLK_DIV=4 unless stated):
- Reset then load 0x1234 → after the next wrap, an_o cycles 1110,1101,1011,0111 with seg_o 1001100,0000110,0010010,1001111; each digit held 4 cycles.
- Load 0xABCD mid-frame at idx=1 → the remaining digits of the current frame still show the old value; the new value appears only from the digit-0 slot after frame_o pulses.
- Two loads within one frame (0x1111, then 0x2222) → the next frame shows 2222 only; frame_o is a single-cycle pulse every 16 cycles.
- Load coincident with a wrap tick, value 0x00F0 → digit 0 of the very next slot shows "0" (0000001), and digit 1 shows F (0111000).
- blank_i=4'b0101 with value 0x8888 → digits 0 and 2 show seg_o 1111111 with anodes still scanned; digits 1 and 3 show 0000000.
- With SSD_LZB_EN defined, value 0x0070:
  - digits 3 and 2 are blank, digit 1 shows 7 (0001111), digit 0 shows 0.
  - Assert rst_n=0 mid-slot → seg_o=1111111 and an_o=1111 immediately.

Source files
------------

// File: rtl/ssd_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ssd_pkg
// Brief    : Shared constants and helpers for the seven-segment scan driver.
// Revision : 1.0 - initial release
// ============================================================================
package ssd_pkg;

    // Active-low {a,b,c,d,e,f,g}; entry n is the glyph for hex digit n.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'b0111000, 7'b0110000, 7'b1000010, 7'b0110001,   // F E d C
        7'b1100000, 7'b0001000, 7'b0000100, 7'b0000000,   // b A 9 8
        7'b0001111, 7'b0100000, 7'b0100100, 7'b1001100,   // 7 6 5 4
        7'b0000110, 7'b0010010, 7'b1001111, 7'b0000001    // 3 2 1 0
    };

    localparam logic [6:0] SEG_OFF = 7'b1111111;

    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ssd_hex_decode.sv
`default_nettype none
// ============================================================================
// Module   : ssd_hex_decode
// Brief    : Combinational nibble-to-segment decoder with blank override.
// Revision : 1.0 - initial release
// ============================================================================
module ssd_hex_decode
    import ssd_pkg::*;
#(
    parameter int SEG_ACTIVE_LOW = 1
) (
    input  logic [3:0] nibble_i,
    input  logic       blank_i,
    output logic [6:0] seg_o
);

    logic [6:0] w_code;

    always_comb begin
        w_code = blank_i ? SEG_OFF : SEG_TABLE[nibble_i];
        seg_o  = (SEG_ACTIVE_LOW != 0) ? w_code : ~w_code;
    end

endmodule
`default_nettype wire

// File: rtl/ssd_scan_driver.sv
`default_nettype none
// ============================================================================
// Module   : ssd_scan_driver
// Brief    : Double-buffered, time-multiplexed hex seven-segment scan driver.
//            Optional leading-zero blanking when SSD_LZB_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module ssd_scan_driver
    import ssd_pkg::*;
#(
    parameter int DIGITS         = 4,
    parameter int CLK_DIV        = 50000,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int AN_ACTIVE_LOW  = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4*DIGITS-1:0]   value_i,
    input  logic                  load_i,
    input  logic [DIGITS-1:0]     blank_i,
    output logic [6:0]            seg_o,
    output logic [DIGITS-1:0]     an_o,
    output logic                  frame_o
);

    localparam int CW = idx_width(CLK_DIV);
    localparam int IW = idx_width(DIGITS);

    localparam logic [CW-1:0]     c_cnt_max = CW'(CLK_DIV - 1);
    localparam logic [IW-1:0]     c_idx_max = IW'(DIGITS - 1);
    localparam logic [6:0]        c_seg_off = (SEG_ACTIVE_LOW != 0) ? SEG_OFF : ~SEG_OFF;
    localparam logic [DIGITS-1:0] c_an_off  = (AN_ACTIVE_LOW != 0) ? '1 : '0;

    logic [CW-1:0]       cnt_q, cnt_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [4*DIGITS-1:0] shadow_val_q, shadow_val_d, active_val_q, active_val_d;
    logic [DIGITS-1:0]   shadow_blank_q, shadow_blank_d, active_blank_q, active_blank_d;
    logic                pending_q, pending_d;
    logic [6:0]          seg_q, seg_d;
    logic [DIGITS-1:0]   an_q, an_d;
    logic                frame_q;

    logic                w_tick, w_idx_last, w_wrap;
    logic [DIGITS-1:0]   w_lzb;
    logic [3:0]          w_nibble;
    logic                w_blank;

    assign w_tick     = (cnt_q == c_cnt_max);
    assign w_idx_last = (idx_q == c_idx_max);
    assign w_wrap     = w_tick & w_idx_last;

    assign cnt_d = w_tick ? '0 : cnt_q + CW'(1);
    assign idx_d = !w_tick ? idx_q : (w_idx_last ? '0 : idx_q + IW'(1));

    // A load in the wrap cycle is folded into shadow first, so it reaches active directly.
    always_comb begin
        shadow_val_d   = shadow_val_q;
        shadow_blank_d = shadow_blank_q;
        active_val_d   = active_val_q;
        active_blank_d = active_blank_q;
        pending_d      = pending_q;
        if (load_i) begin
            shadow_val_d   = value_i;
            shadow_blank_d = blank_i;
            pending_d      = 1'b1;
        end
        if (w_wrap && pending_d) begin
            active_val_d   = shadow_val_d;
            active_blank_d = shadow_blank_d;
            pending_d      = 1'b0;
        end
    end

`ifdef SSD_LZB_EN
    logic [DIGITS:0] w_upper_zero;
    assign w_upper_zero[DIGITS] = 1'b1;
    for (genvar k = 0; k < DIGITS; k++) begin : g_lzb
        assign w_upper_zero[k] = w_upper_zero[k+1] & (active_val_q[4*k +: 4] == 4'd0);
        assign w_lzb[k]        = (k != 0) & w_upper_zero[k];
    end
`else
    assign w_lzb = '0;
`endif

    always_comb begin
        w_nibble = 4'd0;
        w_blank  = 1'b0;
        for (int k = 0; k < DIGITS; k++) begin
            if (idx_q == IW'(k)) begin
                w_nibble = active_val_q[4*k +: 4];
                w_blank  = active_blank_q[k] | w_lzb[k];
            end
        end
    end

    ssd_hex_decode #(
        .SEG_ACTIVE_LOW (SEG_ACTIVE_LOW)
    ) u_dec (
        .nibble_i (w_nibble),
        .blank_i  (w_blank),
        .seg_o    (seg_d)
    );

    assign an_d = c_an_off ^ (DIGITS'(1) << idx_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q          <= '0;
            idx_q          <= '0;
            shadow_val_q   <= '0;
            shadow_blank_q <= '0;
            active_val_q   <= '0;
            active_blank_q <= '0;
            pending_q      <= 1'b0;
            seg_q          <= c_seg_off;
            an_q           <= c_an_off;
            frame_q        <= 1'b0;
        end else begin
            cnt_q          <= cnt_d;
            idx_q          <= idx_d;
            shadow_val_q   <= shadow_val_d;
            shadow_blank_q <= shadow_blank_d;
            active_val_q   <= active_val_d;
            active_blank_q <= active_blank_d;
            pending_q      <= pending_d;
            seg_q          <= seg_d;
            an_q           <= an_d;
            frame_q        <= w_wrap;
        end
    end

    assign seg_o   = seg_q;
    assign an_o    = an_q;
    assign frame_o = frame_q;

endmodule
`default_nettype wire

// File: tb/tb_ssd_scan_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_ssd_scan_driver
// Brief    : Self-checking bench for ssd_scan_driver (DIGITS=4, CLK_DIV=4);
//            expectations follow SSD_LZB_EN when it is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ssd_scan_driver;

    localparam int DIGITS  = 4;
    localparam int CLK_DIV = 4;
    localparam logic [6:0] OFF = 7'b1111111;
    localparam logic [6:0] HEX [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    logic        clk;
    logic        rst_n;
    logic [15:0] value_i;
    logic        load_i;
    logic [3:0]  blank_i;
    logic [6:0]  seg_o;
    logic [3:0]  an_o;
    logic        frame_o;

    int n_checks = 0;
    int n_fail   = 0;

    ssd_scan_driver #(
        .DIGITS         (DIGITS),
        .CLK_DIV        (CLK_DIV),
        .SEG_ACTIVE_LOW (1),
        .AN_ACTIVE_LOW  (1)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .value_i (value_i),
        .load_i  (load_i),
        .blank_i (blank_i),
        .seg_o   (seg_o),
        .an_o    (an_o),
        .frame_o (frame_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0]     value;
        logic [3:0]      blank;
        logic [3:0][6:0] seg;   // expected glyph per digit, index = digit
    } vec_t;

    vec_t vecs [5];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: scan position derives from the number of edges since reset.
    int unsigned m_n;
    logic [15:0] m_act_v, m_sh_v;
    logic [3:0]  m_act_b, m_sh_b;
    bit          m_pend;

    task automatic model_reset();
        m_n = 0; m_act_v = '0; m_sh_v = '0; m_act_b = '0; m_sh_b = '0; m_pend = 0;
    endtask

    task automatic model_step(input bit ld, input logic [15:0] v, input logic [3:0] b,
                              output logic [6:0] eseg, output logic [3:0] ean, output bit efr);
        int d;
        bit blanked;
        logic [3:0] nib;
        d       = (m_n / CLK_DIV) % DIGITS;
        nib     = 4'((m_act_v >> (4*d)) & 16'hF);
        blanked = m_act_b[d];
`ifdef SSD_LZB_EN
        if (d > 0 && (m_act_v >> (4*d)) == 16'd0) blanked = 1;
`endif
        eseg = blanked ? OFF : HEX[nib];
        ean  = 4'b1111 ^ (4'b0001 << d);
        efr  = ((m_n % CLK_DIV) == CLK_DIV-1) && (d == DIGITS-1);
        if (ld) begin m_sh_v = v; m_sh_b = b; m_pend = 1; end
        if (efr && m_pend) begin m_act_v = m_sh_v; m_act_b = m_sh_b; m_pend = 0; end
        m_n++;
    endtask

    // k counts negedges since the frame pulse; slot k shows digit (k-1)/4, pulse at k=16.
    task automatic check_slots(input logic [3:0][6:0] exp, input int from_k, input int to_k);
        for (int k = from_k; k <= to_k; k++) begin
            int d;
            @(negedge clk);
            d = (k - 1) / CLK_DIV;
            chk($sformatf("an_k%0d", k),    32'(an_o),    32'(4'b1111 ^ (4'b0001 << d)));
            chk($sformatf("seg_k%0d", k),   32'(seg_o),   32'(exp[d]));
            chk($sformatf("frame_k%0d", k), 32'(frame_o), 32'(k == 16));
        end
    endtask

    task automatic apply_rec(input vec_t r);
        int w;
        @(negedge clk);
        load_i = 1'b1; value_i = r.value; blank_i = r.blank;
        @(negedge clk);
        load_i = 1'b0;
        w = 0;
        while (frame_o !== 1'b1 && w < 40) begin @(negedge clk); w++; end
        chk("frame_wait", 32'(w < 40), 32'd1);
        check_slots(r.seg, 1, 16);
    endtask

    initial begin
        logic [6:0]      eseg;
        logic [3:0]      ean;
        bit              efr;
        bit              ld;
        logic [15:0]     v;
        logic [3:0]      b;
        logic [3:0][6:0] e1234, eabcd, e2222, e00f0;

        vecs[0] = '{16'h1234, 4'b0000, {7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100}};
        vecs[1] = '{16'h8888, 4'b0101, {7'b0000000, OFF, 7'b0000000, OFF}};
`ifdef SSD_LZB_EN
        vecs[2] = '{16'h0070, 4'b0000, {OFF, OFF, 7'b0001111, 7'b0000001}};
        vecs[3] = '{16'h0000, 4'b0000, {OFF, OFF, OFF, 7'b0000001}};
        e00f0   = {OFF, OFF, 7'b0111000, 7'b0000001};
`else
        vecs[2] = '{16'h0070, 4'b0000, {7'b0000001, 7'b0000001, 7'b0001111, 7'b0000001}};
        vecs[3] = '{16'h0000, 4'b0000, {7'b0000001, 7'b0000001, 7'b0000001, 7'b0000001}};
        e00f0   = {7'b0000001, 7'b0000001, 7'b0111000, 7'b0000001};
`endif
        vecs[4] = '{16'hFEDC, 4'b1000, {OFF, 7'b0110000, 7'b1000010, 7'b0110001}};
        e1234   = vecs[0].seg;
        eabcd   = {7'b0001000, 7'b1100000, 7'b0110001, 7'b1000010};
        e2222   = {7'b0010010, 7'b0010010, 7'b0010010, 7'b0010010};

        rst_n = 1'b1; load_i = 1'b0; value_i = '0; blank_i = '0;
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_seg",   32'(seg_o),   32'(OFF));
        chk("rst_an",    32'(an_o),    32'hF);
        chk("rst_frame", 32'(frame_o), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("first_an",  32'(an_o),  32'b1110);
        chk("first_seg", 32'(seg_o), 32'(7'b0000001));

        for (int i = 0; i < 5; i++) apply_rec(vecs[i]);

        // Mid-frame load: old value finishes the frame, new one starts at digit 0.
        apply_rec(vecs[0]);
        check_slots(e1234, 1, 4);
        load_i = 1'b1; value_i = 16'hABCD; blank_i = '0;
        check_slots(e1234, 5, 5);
        load_i = 1'b0;
        check_slots(e1234, 6, 16);
        check_slots(eabcd, 1, 16);

        // Two loads in one frame: last write wins.
        check_slots(eabcd, 1, 2);
        load_i = 1'b1; value_i = 16'h1111;
        check_slots(eabcd, 3, 3);
        value_i = 16'h2222;
        check_slots(eabcd, 4, 4);
        load_i = 1'b0;
        check_slots(eabcd, 5, 16);
        check_slots(e2222, 1, 16);

        // Load in the wrap cycle goes straight to the display.
        check_slots(e2222, 1, 15);
        load_i = 1'b1; value_i = 16'h00F0;
        check_slots(e2222, 16, 16);
        load_i = 1'b0;
        check_slots(e00f0, 1, 16);
        check_slots(e00f0, 1, 16);

        // Randomised run against the model, with one asynchronous reset mid-slot.
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 1500; i++) begin
            if (i == 700) begin
                load_i = 1'b0;
                #2 rst_n = 1'b0;
                #1;
                chk("async_seg",   32'(seg_o),   32'(OFF));
                chk("async_an",    32'(an_o),    32'hF);
                chk("async_frame", 32'(frame_o), 32'd0);
                @(negedge clk);
                rst_n = 1'b1;
                model_reset();
            end
            ld = ($urandom_range(0, 7) == 0);
            v  = ($urandom_range(0, 1) == 0) ? 16'($urandom) : 16'($urandom_range(0, 255));
            b  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'd0;
            load_i = ld; value_i = v; blank_i = b;
            model_step(ld, v, b, eseg, ean, efr);
            @(negedge clk);
            chk("rnd_seg",   32'(seg_o),   32'(eseg));
            chk("rnd_an",    32'(an_o),    32'(ean));
            chk("rnd_frame", 32'(frame_o), 32'(efr));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
